// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   RV32I load/store unit sitting between the execute stage and a word-only
//   data memory. Loads are decoded combinationally (lane select + sign/zero
//   extension). SW writes in one cycle. SB/SH need a read-modify-write:
//   the word is read and merged in IDLE (stalling the core), then written
//   back from RMW_WR on the following cycle. Misaligned accesses and
//   illegal funct3 codes are flagged and suppress any write.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req, we        memory instruction present / store (1) or load (0)
//   funct3         access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata    byte address and store data from execute
//   rdata          extended load data to writeback
//   stall          core must hold PC and instruction this cycle
//   misalign       current request is misaligned or has an illegal funct3
//   mem_wr_en      data memory write enable
//   mem_addr       word-aligned data memory address
//   mem_wr_data    data memory write word
//   mem_rd_data    data memory asynchronous read word
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  misalign,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] saved_addr;
   logic [DATA_WIDTH-1:0] saved_word;

   logic [1:0]            off;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  illegal;
   logic                  bad_align;
   logic                  req_bad;
   logic                  sub_store;
   logic                  word_store;

   // Shift the addressed lane down to bit 0 and extend it to a full word.
   function automatic logic [DATA_WIDTH-1:0] load_extend(
      input logic [DATA_WIDTH-1:0] word,
      input logic [2:0]            f3,
      input logic [1:0]            lane
   );
      logic [DATA_WIDTH-1:0] sh;
      sh = word >> {lane, 3'b000};
      case (f3)
         3'b000:  return {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         3'b001:  return {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         3'b010:  return word;
         3'b100:  return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
         3'b101:  return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
         default: return '0;
      endcase
   endfunction

   // Insert the low byte/half of the store data at the addressed lane,
   // keeping the other bytes of the word read from memory.
   function automatic logic [DATA_WIDTH-1:0] merge_store(
      input logic [DATA_WIDTH-1:0] word,
      input logic [DATA_WIDTH-1:0] data,
      input logic [2:0]            f3,
      input logic [1:0]            lane
   );
      logic [DATA_WIDTH-1:0] mask;
      logic [DATA_WIDTH-1:0] ins;
      if (f3[1:0] == 2'b00) begin
         mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << {lane, 3'b000};
         ins  = {{(DATA_WIDTH-8){1'b0}}, data[7:0]} << {lane, 3'b000};
      end else begin
         mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << {lane, 3'b000};
         ins  = {{(DATA_WIDTH-16){1'b0}}, data[15:0]} << {lane, 3'b000};
      end
      return (word & ~mask) | (ins & mask);
   endfunction

   // Request decode
   assign off       = addr[1:0];
   assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};
   assign illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
   assign bad_align = ((funct3[1:0] == 2'b01) && off[0]) ||
                      ((funct3[1:0] == 2'b10) && (off != 2'b00));
   assign req_bad    = req && (illegal || bad_align);
   assign sub_store  = req && we && !req_bad && (funct3[1:0] != 2'b10);
   assign word_store = req && we && !req_bad && (funct3 == 3'b010);

   // State register and read-modify-write capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         saved_addr <= '0;
         saved_word <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && sub_store) begin
            saved_addr <= word_addr;
            saved_word <= merge_store(mem_rd_data, wdata, funct3, off);
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sub_store) state_nxt = RMW_WR;
         RMW_WR:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic; reset forces all control outputs and rdata low at once,
   // which also drops a pending RMW write.
   always_comb begin
      rdata       = '0;
      stall       = 1'b0;
      misalign    = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = word_addr;
      mem_wr_data = wdata;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (req_bad) begin
                  misalign = 1'b1;
               end else begin
                  rdata = load_extend(mem_rd_data, funct3, off);
                  if (word_store) mem_wr_en = 1'b1;
                  if (sub_store)  stall     = 1'b1;
               end
            end
            RMW_WR: begin
               mem_wr_en   = 1'b1;
               mem_addr    = saved_addr;
               mem_wr_data = saved_word;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        misalign;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   logic [31:0] mem [0:15];

   int n_tests = 0;
   int n_fail  = 0;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .we          (we),
      .funct3      (funct3),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .stall       (stall),
      .misalign    (misalign),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-only memory with asynchronous read
   assign mem_rd_data = mem[mem_addr[5:2]];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wr_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = r; we = w; funct3 = f3; addr = a; wdata = d;
      #1;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] exp);
      drive(1'b1, 1'b0, f3, a, 32'h0);
      check({tag, "_rdata"}, rdata, exp);
      check({tag, "_stall"}, {31'b0, stall}, 32'h0);
      check({tag, "_wr_en"}, {31'b0, mem_wr_en}, 32'h0);
   endtask

   task automatic do_bad(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a);
      drive(1'b1, w, f3, a, 32'hFFFF_FFFF);
      check({tag, "_misalign"}, {31'b0, misalign}, 32'h1);
      check({tag, "_wr_en"}, {31'b0, mem_wr_en}, 32'h0);
      check({tag, "_stall"}, {31'b0, stall}, 32'h0);
      check({tag, "_rdata"}, rdata, 32'h0);
   endtask

   // Sub-word store: stall cycle, then the merged write cycle.
   task automatic do_sub_store(input string tag, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_word);
      drive(1'b1, 1'b1, f3, a, d);
      check({tag, "_stall1"}, {31'b0, stall}, 32'h1);
      check({tag, "_wr_en1"}, {31'b0, mem_wr_en}, 32'h0);
      check({tag, "_addr1"}, mem_addr, {a[31:2], 2'b00});
      @(negedge clk);
      #1;
      check({tag, "_stall2"}, {31'b0, stall}, 32'h0);
      check({tag, "_wr_en2"}, {31'b0, mem_wr_en}, 32'h1);
      check({tag, "_addr2"}, mem_addr, {a[31:2], 2'b00});
      check({tag, "_wdata2"}, mem_wr_data, exp_word);
   endtask

   initial begin
      rst = 1'b1; req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h1; wdata = 32'hAB;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0] = 32'h80FF_7F01;
      mem[1] = 32'h1122_3344;
      #2;
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_misalign", {31'b0, misalign}, 32'h0);
      check("rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; req = 1'b0;

      // Loads from 0x80FF_7F01
      do_load("lb1",  3'b000, 32'h1, 32'h0000_007F);
      do_load("lb2",  3'b000, 32'h2, 32'hFFFF_FFFF);
      do_load("lbu3", 3'b100, 32'h3, 32'h0000_0080);
      do_load("lh2",  3'b001, 32'h2, 32'hFFFF_80FF);
      do_load("lhu2", 3'b101, 32'h2, 32'h0000_80FF);
      do_load("lw0",  3'b010, 32'h0, 32'h80FF_7F01);

      // SW
      drive(1'b1, 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF);
      check("sw_wr_en", {31'b0, mem_wr_en}, 32'h1);
      check("sw_stall", {31'b0, stall}, 32'h0);
      check("sw_addr", mem_addr, 32'h8);
      check("sw_data", mem_wr_data, 32'hDEAD_BEEF);
      do_load("lw8", 3'b010, 32'h8, 32'hDEAD_BEEF);

      // SB then SH back to back on word 0x4
      do_sub_store("sb6", 3'b000, 32'h6, 32'h0000_00AB, 32'h11AB_3344);
      do_sub_store("sh4", 3'b001, 32'h4, 32'h0000_CAFE, 32'h11AB_CAFE);
      do_load("lw4", 3'b010, 32'h4, 32'h11AB_CAFE);

      // Misaligned / illegal
      do_bad("lw2",   1'b0, 3'b010, 32'h2);
      do_bad("sh3",   1'b1, 3'b001, 32'h3);
      do_bad("f3011", 1'b0, 3'b011, 32'h4);
      do_bad("sb_f3111", 1'b1, 3'b111, 32'h4);
      @(negedge clk);
      req = 1'b0;
      check("bad_mem0", mem[0], 32'h80FF_7F01);
      check("bad_mem1", mem[1], 32'h11AB_CAFE);

      // Reset during RMW_WR
      drive(1'b1, 1'b1, 3'b000, 32'h4, 32'h0000_0055);
      check("rr_stall", {31'b0, stall}, 32'h1);
      @(negedge clk);
      #1;
      check("rr_wr_en_pre", {31'b0, mem_wr_en}, 32'h1);
      rst = 1'b1;
      #1;
      check("rr_wr_en_rst", {31'b0, mem_wr_en}, 32'h0);
      check("rr_stall_rst", {31'b0, stall}, 32'h0);
      @(posedge clk);
      #1;
      check("rr_mem1", mem[1], 32'h11AB_CAFE);
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      do_load("rr_lbu4", 3'b100, 32'h4, 32'h0000_00FE);
      do_sub_store("rr_sb7", 3'b000, 32'h7, 32'h0000_0099, 32'h99AB_CAFE);
      @(negedge clk);
      req = 1'b0;
      check("rr_mem1_after", mem[1], 32'h99AB_CAFE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
